// File: rtl/sigdel_seq.sv
// Conversion sequencer for the sigma-delta ADC datapath: config latch, settle discard, result capture.
// Optional result averaging is enabled with `define SIGDEL_SEQ_AVG_EN.
module sigdel_seq #(
  parameter int unsigned DW       = 16,
  parameter int unsigned CFG_WAIT = 4,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          cont,
  input  logic [5:0]    cfg_in,
  input  logic          conv_stb,
  input  logic [DW-1:0] conv_data,
  input  logic          res_ready,
  output logic [5:0]    cfg_out,
  output logic [DW-1:0] res_data,
  output logic          res_valid,
  output logic          busy,
  output logic          overrun,
  output logic [2:0]    state
);

  localparam int unsigned CW = $clog2(CFG_WAIT + 4);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONFIG  = 3'd1,
    S_SETTLE  = 3'd2,
    S_CONVERT = 3'd3
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    cfg_q, cfg_d;
  logic          cont_q, cont_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_valid_q, res_valid_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;

  logic          stb_cvt;
  logic          cap;
  logic [DW-1:0] cap_data;

  // A strobe coinciding with stop is dropped.
  assign stb_cvt = (state_q == S_CONVERT) && conv_stb && !stop;

`ifdef SIGDEL_SEQ_AVG_EN
  localparam int unsigned AW = DW + AVG_LOG2;
  localparam int unsigned NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [AW-1:0] acc_q, acc_d, acc_sum;
  logic [NW-1:0] nacc_q, nacc_d;
  logic          last;

  // Accumulator is held at zero outside CONVERT, so it starts clean on entry.
  always_comb begin
    acc_d    = acc_q;
    nacc_d   = nacc_q;
    acc_sum  = acc_q + AW'(conv_data);
    last     = (nacc_q == NW'((1 << AVG_LOG2) - 1));
    cap      = stb_cvt && last;
    cap_data = DW'(acc_sum >> AVG_LOG2);
    if ((state_q != S_CONVERT) || stop) begin
      acc_d  = '0;
      nacc_d = '0;
    end else if (conv_stb) begin
      if (last) begin
        acc_d  = '0;
        nacc_d = '0;
      end else begin
        acc_d  = acc_sum;
        nacc_d = nacc_q + NW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      nacc_q <= '0;
    end else begin
      acc_q  <= acc_d;
      nacc_q <= nacc_d;
    end
  end
`else
  always_comb begin
    cap      = stb_cvt;
    cap_data = conv_data;
  end
`endif

  // Next-state, handshake and sticky overrun.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
    if (cap) begin
      res_data_d  = cap_data;
      res_valid_d = 1'b1;
      if (res_valid_q && !res_ready) begin
        overrun_d = 1'b1;
      end
    end

    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cfg_d     = cfg_in;
            cont_d    = cont;
            overrun_d = 1'b0;
            cnt_d     = '0;
            state_d   = S_CONFIG;
          end
        end
        S_CONFIG: begin
          if (cnt_q == CW'(CFG_WAIT - 1)) begin
            cnt_d   = CW'(cfg_q[5:4]);
            state_d = S_SETTLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SETTLE: begin
          // cnt_q holds the number of filter results still to discard.
          if (cnt_q == '0) begin
            state_d = S_CONVERT;
          end else if (conv_stb) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_d = S_CONVERT;
            end
          end
        end
        S_CONVERT: begin
          if (cap && !cont_q) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      cont_q      <= 1'b0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      cont_q      <= cont_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign cfg_out   = cfg_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sigdel_seq.sv
// Scoreboard bench for sigdel_seq: directed stimulus, results checked on each valid/ready transfer.
module tb_sigdel_seq;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, cont;
  logic [5:0]    cfg_in;
  logic          conv_stb;
  logic [DW-1:0] conv_data;
  logic          res_ready;
  logic [5:0]    cfg_out;
  logic [DW-1:0] res_data;
  logic          res_valid, busy, overrun;
  logic [2:0]    state;

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] sb[$];

  sigdel_seq #(.DW(DW), .CFG_WAIT(4), .AVG_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .cfg_in(cfg_in), .conv_stb(conv_stb), .conv_data(conv_data),
    .res_ready(res_ready), .cfg_out(cfg_out), .res_data(res_data),
    .res_valid(res_valid), .busy(busy), .overrun(overrun), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every accepted result must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    logic [DW-1:0] exp_d;
    if (rst_n && res_valid && res_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got 0x%0h with empty scoreboard at %0t", res_data, $time);
      end else begin
        exp_d = sb.pop_front();
        if (res_data === exp_d) n_pass++;
        else $display("FAIL sb_data: got 0x%0h expected 0x%0h at %0t", res_data, exp_d, $time);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [5:0] c, input logic m);
    start = 1'b1; cfg_in = c; cont = m;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic strobe(input logic [DW-1:0] d);
    conv_stb = 1'b1; conv_data = d;
    cycles(1);
    conv_stb = 1'b0;
  endtask

  task automatic take();
    res_ready = 1'b1;
    cycles(1);
    res_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; cfg_in = '0;
    conv_stb = 1'b0; conv_data = '0; res_ready = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // Asynchronous reset mid-cycle from a busy state
    do_start(6'b101010, 1'b1);
    chk("start_state", 32'(state), 32'd1);
    chk("start_cfg", 32'(cfg_out), 32'h2a);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg", 32'(cfg_out), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cycles(1);

    // Single-shot SINC3: strobe in CONFIG ignored, three discards, then capture
    sb.push_back(16'h0444);
    do_start(6'b110110, 1'b0);
    chk("s3_cfg", 32'(cfg_out), 32'h36);
    strobe(16'h0bad);
    cycles(2);
    chk("s3_config_hold", 32'(state), 32'd1);
    cycles(1);
    chk("s3_settle", 32'(state), 32'd2);
    strobe(16'h0011);
    strobe(16'h0022);
    chk("s3_still_settle", 32'(state), 32'd2);
    strobe(16'h0033);
    chk("s3_convert", 32'(state), 32'd3);
    chk("s3_no_result", 32'(res_valid), 32'd0);
    strobe(16'h0444);
    chk("s3_data", 32'(res_data), 32'h0444);
    chk("s3_valid", 32'(res_valid), 32'd1);
    chk("s3_idle", 32'(state), 32'd0);
    chk("s3_busy", 32'(busy), 32'd0);
    take();
    chk("s3_taken", 32'(res_valid), 32'd0);

    // AVG continuous with backpressure, then transfer+capture in one cycle
    do_start(6'b000000, 1'b1);
    cycles(4);
    chk("avg_settle", 32'(state), 32'd2);
    cycles(1);
    chk("avg_convert", 32'(state), 32'd3);
    strobe(16'h0100);
    chk("avg_d1", 32'(res_data), 32'h0100);
    chk("avg_ovr0", 32'(overrun), 32'd0);
    strobe(16'h0200);
    chk("avg_d2", 32'(res_data), 32'h0200);
    chk("avg_ovr1", 32'(overrun), 32'd1);
    sb.push_back(16'h0200);
    sb.push_back(16'h0300);
    res_ready = 1'b1;
    strobe(16'h0300);
    chk("avg_xcap_valid", 32'(res_valid), 32'd1);
    chk("avg_xcap_data", 32'(res_data), 32'h0300);
    cycles(1);
    res_ready = 1'b0;
    chk("avg_drained", 32'(res_valid), 32'd0);

    // start while busy is ignored; mode stays continuous
    do_start(6'b111111, 1'b0);
    chk("ign_cfg", 32'(cfg_out), 32'd0);
    chk("ign_state", 32'(state), 32'd3);
    strobe(16'h0400);
    chk("ign_cont", 32'(state), 32'd3);
    chk("ign_data", 32'(res_data), 32'h0400);

    // stop with a coincident strobe keeps the pending result
    stop = 1'b1; conv_stb = 1'b1; conv_data = 16'h0500;
    cycles(1);
    stop = 1'b0; conv_stb = 1'b0;
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_data", 32'(res_data), 32'h0400);
    chk("stop_valid", 32'(res_valid), 32'd1);
    chk("stop_ovr_sticky", 32'(overrun), 32'd1);

    // Abort SINC2 during SETTLE after one strobe
    do_start(6'b100000, 1'b0);
    chk("s2_ovr_clear", 32'(overrun), 32'd0);
    chk("s2_cfg", 32'(cfg_out), 32'h20);
    cycles(4);
    chk("s2_settle", 32'(state), 32'd2);
    strobe(16'h0055);
    chk("s2_one_discard", 32'(state), 32'd2);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(res_valid), 32'd1);
    chk("abort_data", 32'(res_data), 32'h0400);

    // stop and start together: stop wins
    stop = 1'b1; start = 1'b1; cfg_in = 6'b001100;
    cycles(1);
    stop = 1'b0; start = 1'b0;
    chk("ss_state", 32'(state), 32'd0);
    chk("ss_cfg", 32'(cfg_out), 32'h20);
    sb.push_back(16'h0400);
    take();
    chk("pend_taken", 32'(res_valid), 32'd0);

    // SINC1 single shot: one discard, then capture (averaged when enabled)
    do_start(6'b010000, 1'b0);
    chk("s1_cfg", 32'(cfg_out), 32'h10);
    chk("s1_ovr", 32'(overrun), 32'd0);
    cycles(4);
    chk("s1_settle", 32'(state), 32'd2);
    strobe(16'h0099);
    chk("s1_convert", 32'(state), 32'd3);
`ifdef SIGDEL_SEQ_AVG_EN
    strobe(16'd10);
    strobe(16'd11);
    strobe(16'd12);
    chk("s1_avg_pending", 32'(res_valid), 32'd0);
    chk("s1_avg_state", 32'(state), 32'd3);
    sb.push_back(16'd11);
    strobe(16'd14);
    chk("s1_avg_data", 32'(res_data), 32'd11);
`else
    sb.push_back(16'd10);
    strobe(16'd10);
    chk("s1_data", 32'(res_data), 32'd10);
`endif
    chk("s1_idle", 32'(state), 32'd0);
    chk("s1_valid", 32'(res_valid), 32'd1);
    take();
    chk("s1_taken", 32'(res_valid), 32'd0);

    cycles(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sigdel_seq.md
Name: sigdel_seq

Overview:
- Conversion sequencer for the passive sigma-delta ADC datapath.
- Latches a host configuration (sample rate, oversampling ratio, filter order) and drives it onto the datapath select lines.
- Waits out the filter settling period, then captures filtered results on the decimation strobe and hands them to a consumer over a valid/ready handshake.
- Supports single-shot and continuous conversion.

Parameters:
- DW, 16, result width; must equal the datapath filter output width.
- CFG_WAIT, 4, clocks held in CONFIG after cfg_out changes, before strobes are counted.
- AVG_LOG2, 2, log2 of the number of results averaged; used only with SIGDEL_SEQ_AVG_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- stop  in  1  abort; any state returns to IDLE.
- cont  in  1  sampled with start: 1 = continuous, 0 = single shot.
- cfg_in  in  6  [1:0] rate select, [3:2] oversampling select, [5:4] filter (00 AVG, 01 SINC1, 10 SINC2, 11 SINC3).
- conv_stb  in  1  one-cycle pulse from the datapath marking a new decimated result.
- conv_data  in  DW  filter output; valid in the conv_stb cycle.
- res_ready  in  1  consumer accepts res_data.
- cfg_out  out  6  configuration driven to the datapath mux selects.
- res_data  out  DW  captured result.
- res_valid  out  1  res_data holds an untaken result.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky: a result was overwritten before it was taken.
- state  out  3  encoded state: IDLE=0, CONFIG=1, SETTLE=2, CONVERT=3.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all outputs 0; internal counters 0.
- IDLE:
  - start & !stop: latch cfg_in into cfg_out and cont into the mode register; clear overrun; go to CONFIG on the same edge.
  - cfg_out changes only on this transition.
- CONFIG:
  - Counts CFG_WAIT clocks, then goes to SETTLE.
  - conv_stb is ignored while in CONFIG.
- SETTLE:
  - Discard count D = cfg_out[5:4] (AVG 0, SINC1 1, SINC2 2, SINC3 3).
  - Each conv_stb decrements the remaining count.
  - When D strobes have been seen, go to CONVERT. If D = 0, go to CONVERT on the next edge without waiting for a strobe.
- CONVERT, on conv_stb:
  - res_data <= conv_data and res_valid <= 1 on that edge; res_valid is visible the cycle after the strobe.
  - If res_valid & !res_ready in the same cycle: overwrite res_data and set overrun.
  - Single mode: go to IDLE after the capture.
  - Continuous mode: stay in CONVERT.
- Handshake:
  - Transfer occurs when res_valid & res_ready; res_valid clears next edge.
  - Transfer and capture in the same cycle: res_valid stays 1 with the new data; overrun is not set.
  - res_data is held stable while res_valid & !res_ready.
- stop:
  - Highest priority; any state goes to IDLE next edge.
  - A conv_stb in the same cycle is ignored.
  - res_valid and res_data are untouched, so a pending result can still be taken.
  - stop & start together: stop wins, stays IDLE.
- start while busy: ignored; no config change.
- overrun: cleared only by reset or an accepted start.

Optional Feature:
- Macro: SIGDEL_SEQ_AVG_EN.
- Defined:
  - In CONVERT, accumulate 2^AVG_LOG2 consecutive conv_data values in a DW+AVG_LOG2 accumulator.
  - After the last one, capture acc >> AVG_LOG2 (truncating) into res_data using the same capture/overrun rules.
  - Clear the accumulator and count after each capture, on stop, and on entering CONVERT.
  - Single mode returns to IDLE after one averaged result.
- Undefined: every conv_stb in CONVERT captures directly; no accumulator logic is synthesised.

Test Plan:
- Reset check: drive rst_n low mid-cycle -> state=0, busy=0, res_valid=0, overrun=0, cfg_out=0 immediately, before any clk edge.
- Single SINC3 conversion: cfg_in=6'b110110, cont=0, start; send strobes with data 0x0011, 0x0022, 0x0033, 0x0444 -> first three discarded; res_data=0x0444, res_valid=1, then state=IDLE; res_ready pulse clears res_valid.
- AVG, continuous with backpressure: cfg_in=6'b000000, cont=1, res_ready=0; strobes 0x0100, 0x0200 -> res_data=0x0200, overrun=1. Assert res_ready together with strobe 0x0300 -> res_valid stays 1, res_data=0x0300.
- Abort: stop during SETTLE of SINC2 after one strobe -> IDLE next edge, busy=0, res_valid unchanged. Then start with cfg_in=6'b010000 -> cfg_out=6'b010000, overrun=0.
- Ignored start: start pulse while in CONVERT with a different cfg_in -> cfg_out unchanged, no state change.
- With SIGDEL_SEQ_AVG_EN, AVG_LOG2=2: SINC1, single mode; after one discarded strobe, strobes 10, 11, 12, 14 -> res_data=11 (47>>2); state=IDLE.
